// File: rtl/smc_arb_lite10_pkg.sv
// Shared state encoding and default sizing for the SMC round-robin arbiter.
package smc_arb_pkg10;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_TIMEOUT_CYC = 255;

    // 2'b11 is never produced; the FSM decodes it as ARB_IDLE.
    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE  = 2'b00;
    localparam arb_state_t ARB_GRANT = 2'b01;
    localparam arb_state_t ARB_BUSY  = 2'b10;

endpackage

// File: rtl/smc_arb_lite10_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after i_ptr.
module smc_rr_pick10 #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    input  logic [NUM_REQ-1:0] i_excl,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_vld
);

    logic [NUM_REQ-1:0] w_elig;

    assign w_elig = i_req & ~i_excl;

    always_comb begin
        int idx;
        o_gnt = '0;
        o_vld = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(i_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!o_vld && w_elig[idx]) begin
                o_gnt[idx] = 1'b1;
                o_vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/smc_arb_lite10.sv
// Round-robin arbiter sharing one SMC state machine among NUM_REQ requesters.
// Optional grant locking is enabled by defining SMC_ARB_LOCK_EN.
module smc_arb_lite10
    import smc_arb_pkg10::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               sys_clk10,
    input  logic               sys_reset10,
    input  logic [NUM_REQ-1:0] req10,
    input  logic [NUM_REQ-1:0] req_n_read10,
    input  logic [NUM_REQ-1:0] req_cs10,
    input  logic [NUM_REQ-1:0] req_lock10,
    input  logic               valid_access10,
    input  logic               smc_done10,
    input  logic               mac_done10,
    output logic               new_access10,
    output logic               n_read10,
    output logic               cs10,
    output logic [NUM_REQ-1:0] grant10,
    output logic [NUM_REQ-1:0] req_ack10,
    output logic               arb_err10
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         r_state;
    logic [PW-1:0]      r_ptr;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_n_read;
    logic               r_cs;
    logic               r_err;
    logic [7:0]         r_wdog;

    logic [PW-1:0]      w_gidx;
    logic [PW-1:0]      w_gnext;
    logic [PW-1:0]      w_pick_ptr;
    logic [NUM_REQ-1:0] w_excl;
    logic [NUM_REQ-1:0] w_win;
    logic               w_win_vld;
    logic               w_in_busy;
    logic               w_done;
    logic               w_tmo;
    logic               w_keep;

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (r_grant[i]) w_gidx = PW'(i);
    end

    assign w_gnext   = (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + PW'(1);
    assign w_in_busy = (r_state == ARB_BUSY);
    assign w_done    = smc_done10 & mac_done10;
    assign w_tmo     = (TIMEOUT_CYC != 0) && (r_wdog == 8'(TIMEOUT_CYC - 1));

    // From BUSY the search starts after the current owner, which is masked
    // because its request may still be high in the completion cycle.
    assign w_pick_ptr = w_in_busy ? w_gnext : r_ptr;
    assign w_excl     = w_in_busy ? r_grant : '0;

`ifdef SMC_ARB_LOCK_EN
    assign w_keep = |(req_lock10 & r_grant);
`else
    logic w_unused_lock;
    assign w_unused_lock = ^req_lock10;
    assign w_keep        = 1'b0;
`endif

    smc_rr_pick10 #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .i_req  (req10),
        .i_ptr  (w_pick_ptr),
        .i_excl (w_excl),
        .o_gnt  (w_win),
        .o_vld  (w_win_vld)
    );

    always_ff @(posedge sys_clk10) begin
        if (sys_reset10) begin
            r_state  <= ARB_IDLE;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_ack    <= '0;
            r_n_read <= 1'b1;
            r_cs     <= 1'b0;
            r_err    <= 1'b0;
            r_wdog   <= '0;
        end else begin
            r_ack  <= '0;
            r_err  <= 1'b0;
            r_wdog <= r_wdog + 8'd1;
            case (r_state)
                ARB_GRANT: begin
                    if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_grant <= '0;
                        r_ptr   <= w_gnext;
                        r_state <= ARB_IDLE;
                    end else if (valid_access10) begin
                        r_state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // Completion takes precedence over a coincident timeout.
                    if (w_done) begin
                        r_ack <= r_grant;
                        if (w_keep) begin
                            r_state  <= ARB_GRANT;
                            r_wdog   <= '0;
                            r_n_read <= |(req_n_read10 & r_grant);
                            r_cs     <= |(req_cs10 & r_grant);
                        end else begin
                            r_ptr <= w_gnext;
                            if (w_win_vld) begin
                                r_state  <= ARB_GRANT;
                                r_grant  <= w_win;
                                r_n_read <= |(req_n_read10 & w_win);
                                r_cs     <= |(req_cs10 & w_win);
                                r_wdog   <= '0;
                            end else begin
                                r_state <= ARB_IDLE;
                                r_grant <= '0;
                            end
                        end
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_grant <= '0;
                        r_ptr   <= w_gnext;
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    if (w_win_vld) begin
                        r_state  <= ARB_GRANT;
                        r_grant  <= w_win;
                        r_n_read <= |(req_n_read10 & w_win);
                        r_cs     <= |(req_cs10 & w_win);
                        r_wdog   <= '0;
                    end
                end
            endcase
        end
    end

    assign new_access10 = (r_state == ARB_GRANT);
    assign n_read10     = r_n_read;
    assign cs10         = r_cs;
    assign grant10      = r_grant;
    assign req_ack10    = r_ack;
    assign arb_err10    = r_err;

endmodule

// File: tb/tb_smc_arb_lite10.sv
// Scoreboard bench for smc_arb_lite10: expected grants, acks and errors are
// queued by the stimulus and popped by a negedge monitor.
module tb_smc_arb_lite10;

    localparam int N = 4;

    logic         sys_clk10 = 1'b0;
    logic         sys_reset10;
    logic [N-1:0] req10, req_n_read10, req_cs10, req_lock10;
    logic         valid_access10, smc_done10, mac_done10;
    logic         new_access10, n_read10, cs10, arb_err10;
    logic [N-1:0] grant10, req_ack10;

    typedef struct packed {
        logic [N-1:0] grant;
        logic         n_read;
        logic         cs;
    } gexp_t;

    gexp_t        q_grant[$];
    logic [N-1:0] q_ack[$];
    int           q_err[$];
    int           n_chk  = 0;
    int           n_pass = 0;
    logic         prev_na = 1'b0;

    smc_arb_lite10 #(.NUM_REQ(N), .TIMEOUT_CYC(10)) dut (
        .sys_clk10      (sys_clk10),
        .sys_reset10    (sys_reset10),
        .req10          (req10),
        .req_n_read10   (req_n_read10),
        .req_cs10       (req_cs10),
        .req_lock10     (req_lock10),
        .valid_access10 (valid_access10),
        .smc_done10     (smc_done10),
        .mac_done10     (mac_done10),
        .new_access10   (new_access10),
        .n_read10       (n_read10),
        .cs10           (cs10),
        .grant10        (grant10),
        .req_ack10      (req_ack10),
        .arb_err10      (arb_err10)
    );

    always #5 sys_clk10 = ~sys_clk10;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic unexpected(input string nm);
        n_chk++;
        $display("FAIL %s: DUT event with no expected entry", nm);
    endtask

    task automatic tick();
        @(posedge sys_clk10);
        #1;
    endtask

    task automatic push_g(input logic [N-1:0] g, input logic nr, input logic c);
        gexp_t e;
        e.grant  = g;
        e.n_read = nr;
        e.cs     = c;
        q_grant.push_back(e);
    endtask

    task automatic done(input logic v);
        smc_done10 = v;
        mac_done10 = v;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_new_access"}, 32'(new_access10), 32'd0);
        chk({tag, "_n_read"},     32'(n_read10),     32'd1);
        chk({tag, "_cs"},         32'(cs10),         32'd0);
        chk({tag, "_grant"},      32'(grant10),      32'd0);
        chk({tag, "_ack"},        32'(req_ack10),    32'd0);
        chk({tag, "_err"},        32'(arb_err10),    32'd0);
    endtask

    task automatic do_reset();
        sys_reset10 = 1'b1;
        req10 = '0; req_lock10 = '0; valid_access10 = 1'b0;
        done(1'b0);
        tick();
        tick();
        sys_reset10 = 1'b0;
    endtask

    // Monitor: compares every DUT-presented event against the queued expectation.
    always @(negedge sys_clk10) begin
        gexp_t        e;
        logic [N-1:0] a;
        int           t;
        if (new_access10 && !prev_na) begin
            if (q_grant.size() == 0) unexpected("grant_event");
            else begin
                e = q_grant.pop_front();
                chk("grant_vec",   32'(grant10),  32'(e.grant));
                chk("grant_nread", 32'(n_read10), 32'(e.n_read));
                chk("grant_cs",    32'(cs10),     32'(e.cs));
            end
        end
        prev_na = new_access10;
        if (req_ack10 != '0) begin
            if (q_ack.size() == 0) unexpected("ack_event");
            else begin
                a = q_ack.pop_front();
                chk("ack_vec", 32'(req_ack10), 32'(a));
            end
        end
        if (arb_err10) begin
            if (q_err.size() == 0) unexpected("err_event");
            else begin
                t = q_err.pop_front();
                chk("err_grant_clr", 32'(grant10),   32'd0);
                chk("err_no_ack",    32'(req_ack10), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        sys_reset10 = 1'b1;
        req10 = '0; req_n_read10 = '1; req_cs10 = '0; req_lock10 = '0;
        valid_access10 = 1'b0;
        done(1'b0);
        tick();
        tick();
        chk_reset("rst");
        sys_reset10 = 1'b0;
        tick();

        // Single read on requester 2; requester inputs change after grant.
        req10 = 4'b0100; req_n_read10 = 4'b1011; req_cs10 = 4'b0100;
        push_g(4'b0100, 1'b0, 1'b1);
        tick();
        chk("rd_new_access", 32'(new_access10), 32'd1);
        req10 = '0; req_n_read10 = '1; req_cs10 = '0; valid_access10 = 1'b1;
        tick();
        chk("rd_accept_drop", 32'(new_access10), 32'd0);
        chk("rd_nread_stable", 32'(n_read10), 32'd0);
        chk("rd_cs_stable", 32'(cs10), 32'd1);
        valid_access10 = 1'b0;
        smc_done10 = 1'b1;
        tick();
        chk("rd_no_early_ack", 32'(req_ack10), 32'd0);
        mac_done10 = 1'b1;
        q_ack.push_back(4'b0100);
        tick();
        chk("rd_ack", 32'(req_ack10), 32'h4);
        chk("rd_idle_grant", 32'(grant10), 32'd0);
        done(1'b0);
        tick();
        chk("rd_ack_one_cycle", 32'(req_ack10), 32'd0);

        // Fairness: all four requesting, eight back-to-back accesses.
        do_reset();
        req10 = '1; req_n_read10 = 4'b0101; req_cs10 = '1;
        push_g(4'b0001, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            int g, nx;
            g  = i % 4;
            nx = (i + 1) % 4;
            valid_access10 = 1'b1;
            tick();
            valid_access10 = 1'b0;
            done(1'b1);
            q_ack.push_back(4'(1 << g));
            if (i < 7) push_g(4'(1 << nx), req_n_read10[nx], 1'b1);
            else req10 = '0;
            tick();
            done(1'b0);
            if (i < 7) chk("fair_b2b_new_access", 32'(new_access10), 32'd1);
        end
        chk("fair_idle", 32'(grant10), 32'd0);

        // Back-to-back between requesters 0 and 1.
        req10 = 4'b0011; req_n_read10 = '0; req_cs10 = 4'b0011;
        push_g(4'b0001, 1'b0, 1'b1);
        tick();
        valid_access10 = 1'b1;
        tick();
        valid_access10 = 1'b0;
        done(1'b1);
        q_ack.push_back(4'b0001);
        push_g(4'b0010, 1'b0, 1'b1);
        tick();
        done(1'b0);
        req10 = 4'b0010;
        chk("b2b_grant", 32'(grant10), 32'h2);
        chk("b2b_new_access", 32'(new_access10), 32'd1);
        valid_access10 = 1'b1;
        tick();
        valid_access10 = 1'b0;
        done(1'b1);
        q_ack.push_back(4'b0010);
        req10 = '0;
        tick();
        done(1'b0);
        chk("b2b_idle", 32'(new_access10), 32'd0);

        // Reset in BUSY with completion asserted: no ack, pointer back to 0.
        req10 = 4'b0100; req_n_read10 = 4'b1011; req_cs10 = 4'b0100;
        push_g(4'b0100, 1'b0, 1'b1);
        tick();
        req10 = '0;
        valid_access10 = 1'b1;
        tick();
        valid_access10 = 1'b0;
        sys_reset10 = 1'b1;
        done(1'b1);
        tick();
        chk_reset("mid");
        sys_reset10 = 1'b0;
        done(1'b0);
        req10 = '1; req_n_read10 = '1; req_cs10 = 4'b0001;
        push_g(4'b0001, 1'b1, 1'b1);
        tick();
        chk("rst_ptr_zero", 32'(grant10), 32'h1);
        req10 = '0;
        valid_access10 = 1'b1;
        tick();
        valid_access10 = 1'b0;
        done(1'b1);
        q_ack.push_back(4'b0001);
        tick();
        done(1'b0);

        // Watchdog: requester 1 granted, never accepted.
        req10 = 4'b0010; req_n_read10 = '1; req_cs10 = 4'b0010;
        push_g(4'b0010, 1'b1, 1'b1);
        q_err.push_back(1);
        tick();
        req10 = '0;
        lat = -1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (arb_err10 && lat < 0) lat = k;
        end
        chk("wd_latency", 32'(lat), 32'd10);
        chk("wd_grant_clr", 32'(grant10), 32'd0);

        // Pointer advanced past 1: {1,2} requesting must pick 2; completion
        // in the last watchdog cycle wins over the timeout.
        req10 = 4'b0110; req_n_read10 = '0; req_cs10 = 4'b0110;
        push_g(4'b0100, 1'b0, 1'b1);
        tick();
        req10 = '0;
        valid_access10 = 1'b1;
        tick();
        valid_access10 = 1'b0;
        repeat (8) tick();
        done(1'b1);
        q_ack.push_back(4'b0100);
        tick();
        done(1'b0);
        chk("wd_edge_ack", 32'(req_ack10), 32'h4);
        chk("wd_edge_no_err", 32'(arb_err10), 32'd0);
        tick();

`ifdef SMC_ARB_LOCK_EN
        // Lock on requester 3 holds three grants, then release goes to 0.
        do_reset();
        req10 = 4'b1000; req_lock10 = 4'b1000; req_n_read10 = '1; req_cs10 = '1;
        push_g(4'b1000, 1'b1, 1'b1);
        tick();
        req10 = '1;
        for (int i = 0; i < 3; i++) begin
            valid_access10 = 1'b1;
            tick();
            valid_access10 = 1'b0;
            done(1'b1);
            q_ack.push_back(4'b1000);
            req_n_read10 = (i == 0) ? 4'b0111 : 4'b1111;
            if (i < 2) push_g(4'b1000, req_n_read10[3], 1'b1);
            else begin
                req_lock10 = '0;
                push_g(4'b0001, req_n_read10[0], 1'b1);
            end
            tick();
            done(1'b0);
        end
        chk("lock_release", 32'(grant10), 32'h1);
        req10 = '0;
        valid_access10 = 1'b1;
        tick();
        valid_access10 = 1'b0;
        done(1'b1);
        q_ack.push_back(4'b0001);
        tick();
        done(1'b0);
        tick();
`endif

        tick();
        chk("q_grant_drained", 32'(q_grant.size()), 32'd0);
        chk("q_ack_drained",   32'(q_ack.size()),   32'd0);
        chk("q_err_drained",   32'(q_err.size()),   32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/smc_arb_lite10.md
# smc_arb_lite10

Round-robin access arbiter that shares the single static memory controller state machine between `NUM_REQ` on-chip requesters. It sits between the requesters and the SMC state machine. For each access it:
- picks one requester,
- drives `new_access10`, `n_read10` and `cs10` into the SMC,
- holds them stable until the SMC reports completion,
- returns a one-cycle acknowledge to the winner.

It supports back-to-back grants without passing through idle, and has a watchdog that releases a hung access.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, default 255: watchdog limit in cycles, 8-bit. 0 disables the watchdog.

Ports. One clock; reset is synchronous and active-high.
- `sys_clk10` input 1: system clock; all state changes on its rising edge.
- `sys_reset10` input 1: synchronous, active-high reset.
- `req10` input NUM_REQ: per-requester access request, level.
- `req_n_read10` input NUM_REQ: per-requester read strobe; 0 = read, 1 = write.
- `req_cs10` input NUM_REQ: per-requester chip select.
- `req_lock10` input NUM_REQ: per-requester lock; used only with `SMC_ARB_LOCK_EN`.
- `valid_access10` input 1: SMC has accepted the pending access.
- `smc_done10` input 1: SMC is in the last cycle of the access.
- `mac_done10` input 1: all cycles of a multiple access are complete.
- `new_access10` output 1: access request to the SMC.
- `n_read10` output 1: read strobe of the granted requester.
- `cs10` output 1: chip select of the granted requester.
- `grant10` output NUM_REQ: one-hot grant.
- `req_ack10` output NUM_REQ: one-cycle completion pulse to the granted requester.
- `arb_err10` output 1: one-cycle watchdog-expiry pulse.

## Operation
States are ARB_IDLE, ARB_GRANT and ARB_BUSY. They are encoded in 2 bits; code 2'b11 is illegal and decodes to ARB_IDLE.

ARB_IDLE:
- If any `req10` bit is set, pick a winner (see Arbitration).
- Register the one-hot grant, plus the winner's `req_n_read10` and `req_cs10`.
- Next state is ARB_GRANT.

ARB_GRANT:
- `new_access10` = 1.
- When `valid_access10` = 1, go to ARB_BUSY; `new_access10` is 0 from the next cycle.

ARB_BUSY:
- `new_access10` = 0.
- When `smc_done10 & mac_done10`, pulse `req_ack10[g]` for the granted index g and advance the pointer.
- Then select the next state:
  - If another eligible request is present, go directly to ARB_GRANT with the new winner.
  - Otherwise, go to ARB_IDLE and clear `grant10`.

Arbitration:
- A rotating pointer `ptr` is reset to 0. Priority is `ptr`, `ptr+1`, …, modulo NUM_REQ.
- After completion, `ptr` = g+1, wrapping to 0 after NUM_REQ-1.
- When selecting from ARB_BUSY, requester g is excluded, because its `req10` may still be high in the completion cycle.

Stability:
- `n_read10`, `cs10` and `grant10` are registered at grant time.
- They stay constant through ARB_GRANT and ARB_BUSY. Requester input changes are ignored.

Watchdog:
- A counter clears on entry to ARB_GRANT and increments in ARB_GRANT and ARB_BUSY.
- On reaching `TIMEOUT_CYC` (when non-zero):
  - pulse `arb_err10`,
  - assert no `req_ack10`,
  - clear `grant10` and advance `ptr` past g,
  - return to ARB_IDLE.

Simultaneous events:
- Completion and timeout in the same cycle: completion wins; no `arb_err10`.
- `valid_access10` outside ARB_GRANT is ignored.
- `smc_done10` outside ARB_BUSY is ignored.

## Timing
Reset values:
- state = ARB_IDLE and `ptr` = 0.
- `new_access10`, `cs10`, `grant10`, `req_ack10` and `arb_err10` = 0.
- `n_read10` = 1.
- Reset asserted in mid-access takes effect at the next edge and drops `new_access10` without an ack.

Cycle-level latencies:
- Request in IDLE: `req10` sampled at edge N gives `grant10` and `new_access10` high from cycle N+1.
- Acceptance: `valid_access10` high at cycle M gives `new_access10` low at M+1.
- Completion: completion at cycle K gives `req_ack10` high for exactly cycle K+1.
  - Back-to-back: the next grant and `new_access10` also start at K+1.
- Requesters must drop `req10` by the cycle after `req_ack10`; otherwise they are re-eligible.

## Configuration
Macro: `SMC_ARB_LOCK_EN`.

Defined:
- If `req_lock10[g]` = 1 at completion, g keeps the grant. It returns to ARB_GRANT with g and with `n_read10`/`cs10` re-registered.
- The pointer does not advance.
- The timeout still releases the lock.

Undefined:
- `req_lock10` is unused.
- Plain round-robin applies.

## Structure
- Package `smc_arb_pkg10`: state enum, `ARB_IDLE`/`ARB_GRANT`/`ARB_BUSY` encodings, and the default `NUM_REQ` and `TIMEOUT_CYC` constants.
- Sub-module `smc_rr_pick10`: combinational round-robin picker.
  - Inputs: request vector, pointer, exclude mask.
  - Outputs: one-hot winner and a valid flag.

## Test plan
- Single read on requester 2:
  - `req10`=4'b0100 with `req_n_read10[2]`=0 gives `grant10`=4'b0100, `n_read10`=0 and `new_access10`=1 next cycle.
  - `valid_access10` drops `new_access10` one cycle later.
  - `smc_done10&mac_done10` gives `req_ack10`=4'b0100 for one cycle.
- Fairness: hold `req10`=4'b1111 for 8 accesses; grants go in the order 0,1,2,3,0,1,2,3.
- Back-to-back: requesters 0 and 1 both request; at completion of 0, `new_access10` is re-asserted the next cycle with `grant10`=4'b0010 and no IDLE cycle.
- Watchdog: `TIMEOUT_CYC`=10 and `valid_access10` never asserted give `arb_err10` 10 cycles after grant, `grant10`=0 and no `req_ack10`.
- Reset mid-access: assert `sys_reset10` in ARB_BUSY; all outputs take their reset values at the next edge and `ptr`=0.
- With `SMC_ARB_LOCK_EN`: `req_lock10[3]`=1 and all requesting give 3 consecutive grants to requester 3; clearing the lock makes the next grant go to requester 0.
